imgpad_axis_tx: RTL and testbench
=================================

Name: imgpad_axis_tx

Overview:
- AXI4-Stream video transmitter for the lane-detection datapath, on the output side of the row-crop stage.
- Takes unframed, row-major pixels that cover only the cropped rows (the bottom CROP_HEIGHT rows).
- Rebuilds a full IMG_HEIGHT x IMG_WIDTH frame: first emits (IMG_HEIGHT-CROP_HEIGHT) rows of PAD_VALUE, then the cropped rows.
- Generates tuser (start of frame) and tlast (end of line) for downstream video IP.

Parameters:
- DATA_W, 24, pixel width in bits
- IMG_WIDTH, 416, pixels per line
- IMG_HEIGHT, 416, lines per output frame
- CROP_HEIGHT, 416, lines of real data per frame (1..IMG_HEIGHT)
- PAD_VALUE, 0, tdata value for padding pixels

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- enable  in  1  permits a new frame to start; sampled only at frame boundaries
- s_pix_tdata  in  DATA_W  input pixel
- s_pix_tvalid  in  1  input pixel valid
- s_pix_tready  out  1  input pixel accepted when tvalid&&tready
- m_axis_tdata  out  DATA_W  output pixel
- m_axis_tvalid  out  1  output valid
- m_axis_tready  in  1  downstream ready
- m_axis_tuser  out  1  start of frame, first beat of each frame only
- m_axis_tlast  out  1  end of line, beat with col==IMG_WIDTH-1
- frame_done  out  1  one-cycle pulse when the last beat of a frame is accepted

Behaviour:
- Reset values: m_axis_tvalid=0, m_axis_tuser=0, m_axis_tlast=0, m_axis_tdata=0, s_pix_tready=0, frame_done=0. FSM=IDLE; col and row counters=0.
- Derived constant: PAD_ROWS=IMG_HEIGHT-CROP_HEIGHT. Elaboration error if CROP_HEIGHT>IMG_HEIGHT or CROP_HEIGHT==0.
- Counters:
  - col is $clog2(IMG_WIDTH) bits wide; row is $clog2(IMG_HEIGHT) bits wide.
  - Both advance only on an output handshake (m_axis_tvalid&&m_axis_tready).
  - col wraps to 0 at IMG_WIDTH-1, and row then increments.
  - row wraps to 0 at IMG_HEIGHT-1.
- FSM states:
  - IDLE: no output. If enable=1, go to PAD (PAD_ROWS>0) or DATA (PAD_ROWS==0).
  - PAD: the block sources pad beats itself; s_pix_tready=0. Leave for DATA when the beat at row==PAD_ROWS-1, col==IMG_WIDTH-1 is accepted.
  - DATA: pixels pass from s_pix to m_axis. When the beat at row==IMG_HEIGHT-1, col==IMG_WIDTH-1 is accepted, pulse frame_done. Then:
    - enable=1: go to PAD/DATA again (back-to-back frames, no bubble);
    - enable=0: go to IDLE.
- Output stage: a registered AXIS register slice (skid buffer).
  - Latency is 1 cycle from input acceptance (or pad-beat generation) to m_axis_tvalid.
  - Full throughput: 1 beat/cycle when m_axis_tready is held at 1.
  - s_pix_tready is a registered output; it never combinationally depends on m_axis_tready.
- AXIS rules:
  - Once m_axis_tvalid=1, tdata/tuser/tlast are held stable until the handshake.
  - tvalid never drops without a handshake.
  - tuser=1 on the beat with row==0, col==0 only (the pad beat, or the data beat when PAD_ROWS==0).
- Input starvation in DATA: m_axis_tvalid drops once the slice drains. Framing counters hold, so the frame resumes without corruption.
- enable deasserted mid-frame: the current frame completes in full; enable is checked only in IDLE and at frame end.
- Input pixels presented outside DATA are not accepted (s_pix_tready=0). They remain pending upstream.
- Simultaneous input accept and output accept in the same cycle are both honoured; the slice occupancy is unchanged.
- Reset mid-frame: all state clears at once; the partial frame is discarded. The next frame starts at row 0 with tuser after enable.

Decomposition:
- Shared package imgpad_pkg:
  - FSM state enum (IDLE, PAD, DATA);
  - localparam functions for counter widths;
  - PAD_ROWS derivation.
- Sub-module axis_skid_buf (DATA_W+2 payload: tdata, tuser, tlast):
  - 2-entry register slice;
  - registered ready;
  - asynchronous active-low reset.
- Top level holds the FSM, counters, pad/data mux and frame_done.

Test Plan:
1. IMG_WIDTH=4, IMG_HEIGHT=4, CROP_HEIGHT=2, enable=1, tready=1, input pixels 1..8 always valid -> 16 beats.
   - Beats 0-7 = 0; beats 8-15 = 1..8.
   - tuser only on beat 0; tlast on beats 3, 7, 11, 15.
   - frame_done one cycle after beat 15 is accepted.
   - s_pix_tready=0 during pad rows.
2. Same configuration, m_axis_tready toggling 1/0 each cycle, input tvalid random -> identical beat sequence.
   - No beat lost or duplicated.
   - Payload stable while tvalid=1 and tready=0.
3. CROP_HEIGHT=IMG_HEIGHT=4, IMG_WIDTH=4 -> no pad beats; first data pixel carries tuser; 16 beats.
4. enable held at 1 for 2 frames -> frame 2 tuser beat immediately follows frame 1 tlast beat with no idle cycle; frame_done pulses twice.
5. enable dropped at beat 5 of a frame -> frame completes with all 16 beats; FSM goes to IDLE; m_axis_tvalid=0 afterwards.
6. rst_n asserted at beat 10 -> outputs return to reset values asynchronously. After release with enable=1, the next beat has tuser=1 and pad data 0.

Source files
------------

// File: rtl/imgpad_pkg.sv
`default_nettype none
// ============================================================================
// imgpad_pkg -- shared FSM encoding and size helpers for imgpad_axis_tx
// Rev 1.0
// ============================================================================
package imgpad_pkg;

  localparam int STATE_W = 2;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_PAD  = 2'd1;
  localparam logic [1:0] ST_DATA = 2'd2;

  // Counter width for a count of n, never narrower than one bit.
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int pad_rows(input int img_height, input int crop_height);
    return img_height - crop_height;
  endfunction

endpackage
`default_nettype wire

// File: rtl/axis_skid_buf.sv
`default_nettype none
// ============================================================================
// axis_skid_buf -- 2-entry AXI4-Stream register slice with registered ready
// Rev 1.0
// ============================================================================
module axis_skid_buf #(
  parameter int WIDTH = 26
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] s_data,
  input  logic             s_valid,
  output logic             s_ready,
  output logic [WIDTH-1:0] m_data,
  output logic             m_valid,
  input  logic             m_ready
);

  logic [WIDTH-1:0] out_data, out_data_nxt;
  logic             out_valid, out_valid_nxt;
  logic [WIDTH-1:0] skid_data, skid_data_nxt;
  logic             skid_valid, skid_valid_nxt;
  logic             ready_r;
  logic             push;

  assign push = s_valid && ready_r;

  // The skid entry only fills when the output register is held by backpressure.
  always_comb begin
    out_data_nxt   = out_data;
    out_valid_nxt  = out_valid;
    skid_data_nxt  = skid_data;
    skid_valid_nxt = skid_valid;
    if (!skid_valid) begin
      if (!out_valid || m_ready) begin
        out_valid_nxt = push;
        if (push) begin
          out_data_nxt = s_data;
        end
      end else if (push) begin
        skid_valid_nxt = 1'b1;
        skid_data_nxt  = s_data;
      end
    end else if (m_ready) begin
      out_data_nxt   = skid_data;
      skid_valid_nxt = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_data   <= '0;
      out_valid  <= 1'b0;
      skid_data  <= '0;
      skid_valid <= 1'b0;
      ready_r    <= 1'b0;
    end else begin
      out_data   <= out_data_nxt;
      out_valid  <= out_valid_nxt;
      skid_data  <= skid_data_nxt;
      skid_valid <= skid_valid_nxt;
      ready_r    <= !skid_valid_nxt;
    end
  end

  assign s_ready = ready_r;
  assign m_data  = out_data;
  assign m_valid = out_valid;

endmodule
`default_nettype wire

// File: rtl/imgpad_axis_tx.sv
`default_nettype none
// ============================================================================
// imgpad_axis_tx -- rebuilds full AXIS video frames from cropped rows, padding on top
// Rev 1.0
// ============================================================================
module imgpad_axis_tx
  import imgpad_pkg::*;
#(
  parameter int                DATA_W      = 24,
  parameter int                IMG_WIDTH   = 416,
  parameter int                IMG_HEIGHT  = 416,
  parameter int                CROP_HEIGHT = 416,
  parameter logic [DATA_W-1:0] PAD_VALUE   = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              enable,
  input  logic [DATA_W-1:0] s_pix_tdata,
  input  logic              s_pix_tvalid,
  output logic              s_pix_tready,
  output logic [DATA_W-1:0] m_axis_tdata,
  output logic              m_axis_tvalid,
  input  logic              m_axis_tready,
  output logic              m_axis_tuser,
  output logic              m_axis_tlast,
  output logic              frame_done
);

  localparam int CW       = cnt_w(IMG_WIDTH);
  localparam int RW       = cnt_w(IMG_HEIGHT);
  localparam int PAD_ROWS = pad_rows(IMG_HEIGHT, CROP_HEIGHT);
  localparam int PW       = DATA_W + 2;

  localparam logic [CW-1:0]      LAST_COL     = CW'(IMG_WIDTH - 1);
  localparam logic [RW-1:0]      LAST_ROW     = RW'(IMG_HEIGHT - 1);
  localparam logic [RW-1:0]      PAD_LAST_ROW = RW'((PAD_ROWS > 0) ? PAD_ROWS - 1 : 0);
  localparam logic [STATE_W-1:0] FIRST_STATE  = (PAD_ROWS > 0) ? ST_PAD : ST_DATA;

  if (CROP_HEIGHT > IMG_HEIGHT || CROP_HEIGHT < 1) begin : g_bad_crop
    $error("imgpad_axis_tx: CROP_HEIGHT must be in 1..IMG_HEIGHT");
  end

  logic [STATE_W-1:0] state;
  logic [CW-1:0]      gen_col, col;
  logic [RW-1:0]      gen_row, row;
  logic               frame_done_r;

  logic               in_valid, slice_ready, push;
  logic               gen_last_col, gen_last_row, pad_end, frame_end;
  logic [DATA_W-1:0]  beat_data;
  logic [PW-1:0]      in_payload, out_payload;
  logic               out_hs;

  // gen_* count beats entering the slice; col/row count beats leaving it.
  assign gen_last_col = (gen_col == LAST_COL);
  assign gen_last_row = (gen_row == LAST_ROW);
  assign pad_end      = gen_last_col && (gen_row == PAD_LAST_ROW);
  assign frame_end    = gen_last_col && gen_last_row;

  assign in_valid     = (state == ST_PAD) || ((state == ST_DATA) && s_pix_tvalid);
  assign push         = in_valid && slice_ready;
  assign s_pix_tready = (state == ST_DATA) && slice_ready;

  assign beat_data  = (state == ST_PAD) ? PAD_VALUE : s_pix_tdata;
  assign in_payload = {beat_data, (gen_col == '0) && (gen_row == '0), gen_last_col};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      gen_col <= '0;
      gen_row <= '0;
    end else begin
      case (state)
        ST_IDLE: if (enable) state <= FIRST_STATE;
        ST_PAD:  if (push && pad_end) state <= ST_DATA;
        ST_DATA: if (push && frame_end) state <= enable ? FIRST_STATE : ST_IDLE;
        default: state <= ST_IDLE;
      endcase
      if (push) begin
        if (gen_last_col) begin
          gen_col <= '0;
          gen_row <= gen_last_row ? '0 : gen_row + RW'(1);
        end else begin
          gen_col <= gen_col + CW'(1);
        end
      end
    end
  end

  axis_skid_buf #(
    .WIDTH (PW)
  ) u_slice (
    .clk     (clk),
    .rst_n   (rst_n),
    .s_data  (in_payload),
    .s_valid (in_valid),
    .s_ready (slice_ready),
    .m_data  (out_payload),
    .m_valid (m_axis_tvalid),
    .m_ready (m_axis_tready)
  );

  assign {m_axis_tdata, m_axis_tuser, m_axis_tlast} = out_payload;
  assign out_hs = m_axis_tvalid && m_axis_tready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col          <= '0;
      row          <= '0;
      frame_done_r <= 1'b0;
    end else begin
      frame_done_r <= out_hs && (col == LAST_COL) && (row == LAST_ROW);
      if (out_hs) begin
        if (col == LAST_COL) begin
          col <= '0;
          row <= (row == LAST_ROW) ? '0 : row + RW'(1);
        end else begin
          col <= col + CW'(1);
        end
      end
    end
  end

  assign frame_done = frame_done_r;

endmodule
`default_nettype wire

// File: tb/tb_imgpad_axis_tx.sv
`default_nettype none
// ============================================================================
// tb_imgpad_axis_tx -- scoreboard bench for imgpad_axis_tx (4x4 frames)
// Rev 1.0
// ============================================================================
module tb_imgpad_axis_tx;

  localparam int DW  = 16;
  localparam int W   = 4;
  localparam int H   = 4;
  localparam int PAD = 2;
  localparam int LIMIT = 400;

  typedef struct packed {
    logic [DW-1:0] data;
    logic          user;
    logic          last;
  } beat_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic          enable = 1'b0;
  logic [DW-1:0] s_tdata = '0;
  logic          s_tvalid = 1'b0;
  logic          s_tready;
  logic [DW-1:0] m_tdata;
  logic          m_tvalid, m_tuser, m_tlast, frame_done;
  logic          m_tready = 1'b0;

  logic          enable2 = 1'b0;
  logic [DW-1:0] s2_tdata = '0;
  logic          s2_tvalid = 1'b0;
  logic          s2_tready;
  logic [DW-1:0] m2_tdata;
  logic          m2_tvalid, m2_tuser, m2_tlast, done2;
  logic          m2_tready = 1'b0;

  imgpad_axis_tx #(
    .DATA_W(DW), .IMG_WIDTH(W), .IMG_HEIGHT(H), .CROP_HEIGHT(H - PAD)
  ) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable),
    .s_pix_tdata(s_tdata), .s_pix_tvalid(s_tvalid), .s_pix_tready(s_tready),
    .m_axis_tdata(m_tdata), .m_axis_tvalid(m_tvalid), .m_axis_tready(m_tready),
    .m_axis_tuser(m_tuser), .m_axis_tlast(m_tlast), .frame_done(frame_done)
  );

  imgpad_axis_tx #(
    .DATA_W(DW), .IMG_WIDTH(W), .IMG_HEIGHT(H), .CROP_HEIGHT(H)
  ) dut_nopad (
    .clk(clk), .rst_n(rst_n), .enable(enable2),
    .s_pix_tdata(s2_tdata), .s_pix_tvalid(s2_tvalid), .s_pix_tready(s2_tready),
    .m_axis_tdata(m2_tdata), .m_axis_tvalid(m2_tvalid), .m_axis_tready(m2_tready),
    .m_axis_tuser(m2_tuser), .m_axis_tlast(m2_tlast), .frame_done(done2)
  );

  int vectors = 0;
  int miscompares = 0;

  beat_t         exp_q[$];
  logic [DW-1:0] pix_q[$];
  bit            ready_toggle = 0;
  bit            rand_valid = 0;
  bit            out_hs = 0;
  bit            in_hs = 0;
  beat_t         got;
  int            cyc = 0;

  // Queue one full frame: pad beats are expected only; data beats are also sent.
  task automatic push_frame(input logic [DW-1:0] base);
    for (int r = 0; r < H; r++) begin
      for (int c = 0; c < W; c++) begin
        beat_t b;
        b.user = (r == 0 && c == 0);
        b.last = (c == W - 1);
        if (r < PAD) begin
          b.data = '0;
        end else begin
          b.data = base + DW'((r - PAD) * W + c);
          pix_q.push_back(b.data);
        end
        exp_q.push_back(b);
      end
    end
  endtask

  // Drive one cycle of stimulus at negedge and record what the next edge will transfer.
  task automatic cycle();
    @(negedge clk);
    cyc++;
    m_tready = ready_toggle ? ~m_tready : 1'b1;
    if (!(s_tvalid && !in_hs)) begin
      if (pix_q.size() > 0) begin
        s_tvalid = rand_valid ? 1'($urandom_range(0, 1)) : 1'b1;
        s_tdata  = pix_q[0];
      end else begin
        s_tvalid = 1'b0;
      end
    end
    in_hs  = s_tvalid && s_tready;
    out_hs = m_tvalid && m_tready;
    got    = {m_tdata, m_tuser, m_tlast};
    if (in_hs) void'(pix_q.pop_front());
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    vectors++;
    if ({m_tvalid, m_tuser, m_tlast, m_tdata, s_tready, frame_done} !== '0) begin
      miscompares++;
      $display("FAIL reset_outputs got valid=%b user=%b last=%b data=%h sready=%b done=%b want all 0",
               m_tvalid, m_tuser, m_tlast, m_tdata, s_tready, frame_done);
    end
    vectors++;
    if ({m2_tvalid, s2_tready, done2} !== 3'b000) begin
      miscompares++;
      $display("FAIL reset_nopad got valid=%b sready=%b done=%b want 0", m2_tvalid, s2_tready, done2);
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_basic();
    int n = 0;
    int guard = 0;
    bit want_done = 0;
    ready_toggle = 0; rand_valid = 0;
    push_frame(DW'(1));
    enable = 1'b1;
    while ((exp_q.size() > 0 || want_done) && guard < LIMIT) begin
      cycle(); guard++;
      vectors++;
      if (frame_done !== want_done) begin
        miscompares++;
        $display("FAIL basic_frame_done beat=%0d got %b want %b", n, frame_done, want_done);
      end
      want_done = 0;
      if (n < PAD * W - 1) begin
        vectors++;
        if (s_tready !== 1'b0) begin
          miscompares++;
          $display("FAIL basic_pad_sready beat=%0d got %b want 0", n, s_tready);
        end
      end
      if (out_hs) begin
        beat_t e = exp_q.pop_front();
        vectors++;
        if (got !== e) begin
          miscompares++;
          $display("FAIL basic_beat%0d got %h/%b/%b want %h/%b/%b", n, got.data, got.user, got.last, e.data, e.user, e.last);
        end
        if (n == W * H - 1) want_done = 1;
        n++;
        enable = 1'b0;
      end
    end
    if (guard >= LIMIT) begin
      miscompares++;
      $display("FAIL basic_timeout got %0d beats want %0d", n, W * H);
    end
  endtask

  task automatic test_stall();
    int n = 0;
    int guard = 0;
    bit want_done = 0;
    bit prev_stall = 0;
    beat_t prev_got = '0;
    ready_toggle = 1; rand_valid = 1;
    push_frame(DW'(1));
    enable = 1'b1;
    while ((exp_q.size() > 0 || want_done) && guard < LIMIT) begin
      cycle(); guard++;
      vectors++;
      if (frame_done !== want_done) begin
        miscompares++;
        $display("FAIL stall_frame_done beat=%0d got %b want %b", n, frame_done, want_done);
      end
      want_done = 0;
      if (prev_stall) begin
        vectors++;
        if (!m_tvalid || got !== prev_got) begin
          miscompares++;
          $display("FAIL stall_hold got valid=%b %h want valid=1 %h", m_tvalid, got, prev_got);
        end
      end
      prev_stall = m_tvalid && !m_tready;
      prev_got   = got;
      if (out_hs) begin
        beat_t e = exp_q.pop_front();
        vectors++;
        if (got !== e) begin
          miscompares++;
          $display("FAIL stall_beat%0d got %h/%b/%b want %h/%b/%b", n, got.data, got.user, got.last, e.data, e.user, e.last);
        end
        if (n == W * H - 1) want_done = 1;
        n++;
        enable = 1'b0;
      end
    end
    if (guard >= LIMIT) begin
      miscompares++;
      $display("FAIL stall_timeout got %0d beats want %0d", n, W * H);
    end
    ready_toggle = 0; rand_valid = 0;
  endtask

  task automatic test_no_pad();
    beat_t q2[$];
    int k = 0;
    int n = 0;
    int dones = 0;
    int guard = 0;
    enable2 = 1'b1; m2_tready = 1'b1;
    while (n < W * H && guard < LIMIT) begin
      @(negedge clk); guard++;
      if (done2) dones++;
      s2_tvalid = (k < W * H);
      s2_tdata  = DW'(300 + k);
      if (m2_tvalid) begin
        vectors++;
        if (q2.size() == 0) begin
          miscompares++;
          $display("FAIL nopad_extra_beat got %h want none", m2_tdata);
        end else begin
          beat_t e = q2.pop_front();
          if ({m2_tdata, m2_tuser, m2_tlast} !== e) begin
            miscompares++;
            $display("FAIL nopad_beat%0d got %h/%b/%b want %h/%b/%b", n, m2_tdata, m2_tuser, m2_tlast, e.data, e.user, e.last);
          end
        end
        n++;
        enable2 = 1'b0;
      end
      if (s2_tvalid && s2_tready) begin
        q2.push_back({s2_tdata, k == 0, (k % W) == W - 1});
        k++;
      end
    end
    s2_tvalid = 1'b0;
    repeat (3) begin
      @(negedge clk);
      if (done2) dones++;
    end
    vectors++;
    if (n != W * H || dones != 1) begin
      miscompares++;
      $display("FAIL nopad_count got beats=%0d done=%0d want beats=%0d done=1", n, dones, W * H);
    end
  endtask

  task automatic test_back_to_back();
    int n = 0;
    int guard = 0;
    int dones = 0;
    int last_cyc = 0;
    bit want_done = 0;
    push_frame(DW'(101));
    push_frame(DW'(201));
    enable = 1'b1;
    while ((exp_q.size() > 0 || want_done) && guard < LIMIT) begin
      cycle(); guard++;
      if (frame_done) dones++;
      vectors++;
      if (frame_done !== want_done) begin
        miscompares++;
        $display("FAIL b2b_frame_done beat=%0d got %b want %b", n, frame_done, want_done);
      end
      want_done = 0;
      if (out_hs) begin
        beat_t e = exp_q.pop_front();
        vectors++;
        if (got !== e) begin
          miscompares++;
          $display("FAIL b2b_beat%0d got %h/%b/%b want %h/%b/%b", n, got.data, got.user, got.last, e.data, e.user, e.last);
        end
        if (n == W * H) begin
          vectors++;
          if (cyc - last_cyc != 1) begin
            miscompares++;
            $display("FAIL b2b_gap got %0d cycles want 1", cyc - last_cyc);
          end
          enable = 1'b0;
        end
        if ((n % (W * H)) == W * H - 1) want_done = 1;
        last_cyc = cyc;
        n++;
      end
    end
    vectors++;
    if (guard >= LIMIT || dones != 2) begin
      miscompares++;
      $display("FAIL b2b_done_count got %0d (guard %0d) want 2", dones, guard);
    end
  endtask

  task automatic test_enable_drop();
    int n = 0;
    int guard = 0;
    bit want_done = 0;
    rand_valid = 1;
    push_frame(DW'(41));
    enable = 1'b1;
    while ((exp_q.size() > 0 || want_done) && guard < LIMIT) begin
      cycle(); guard++;
      vectors++;
      if (frame_done !== want_done) begin
        miscompares++;
        $display("FAIL drop_frame_done beat=%0d got %b want %b", n, frame_done, want_done);
      end
      want_done = 0;
      if (out_hs) begin
        beat_t e = exp_q.pop_front();
        vectors++;
        if (got !== e) begin
          miscompares++;
          $display("FAIL drop_beat%0d got %h/%b/%b want %h/%b/%b", n, got.data, got.user, got.last, e.data, e.user, e.last);
        end
        if (n == W * H - 1) want_done = 1;
        n++;
        if (n == 5) enable = 1'b0;
      end
    end
    if (guard >= LIMIT) begin
      miscompares++;
      $display("FAIL drop_timeout got %0d beats want %0d", n, W * H);
    end
    rand_valid = 0;
    repeat (10) begin
      cycle();
      vectors++;
      if (m_tvalid !== 1'b0 || s_tready !== 1'b0) begin
        miscompares++;
        $display("FAIL drop_idle got valid=%b sready=%b want 0/0", m_tvalid, s_tready);
      end
    end
  endtask

  task automatic test_reset_midframe();
    int n = 0;
    int guard = 0;
    bit want_done = 0;
    push_frame(DW'(1));
    enable = 1'b1;
    while (n < 10 && guard < LIMIT) begin
      cycle(); guard++;
      if (out_hs) begin
        void'(exp_q.pop_front());
        n++;
      end
    end
    #2 rst_n = 1'b0;
    #1;
    vectors++;
    if ({m_tvalid, m_tuser, m_tlast, m_tdata, s_tready, frame_done} !== '0) begin
      miscompares++;
      $display("FAIL midreset_outputs got valid=%b user=%b last=%b data=%h sready=%b done=%b want all 0",
               m_tvalid, m_tuser, m_tlast, m_tdata, s_tready, frame_done);
    end
    exp_q.delete();
    pix_q.delete();
    s_tvalid = 1'b0;
    in_hs = 0;
    @(negedge clk);
    rst_n = 1'b1;
    push_frame(DW'(51));
    n = 0; guard = 0;
    while ((exp_q.size() > 0 || want_done) && guard < LIMIT) begin
      cycle(); guard++;
      vectors++;
      if (frame_done !== want_done) begin
        miscompares++;
        $display("FAIL midreset_frame_done beat=%0d got %b want %b", n, frame_done, want_done);
      end
      want_done = 0;
      if (out_hs) begin
        beat_t e = exp_q.pop_front();
        vectors++;
        if (got !== e) begin
          miscompares++;
          $display("FAIL midreset_beat%0d got %h/%b/%b want %h/%b/%b", n, got.data, got.user, got.last, e.data, e.user, e.last);
        end
        if (n == W * H - 1) want_done = 1;
        n++;
        enable = 1'b0;
      end
    end
    if (guard >= LIMIT) begin
      miscompares++;
      $display("FAIL midreset_timeout got %0d beats want %0d", n, W * H);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_stall();
    test_no_pad();
    test_back_to_back();
    test_enable_drop();
    test_reset_midframe();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout got no finish want finish before 500000");
    $fatal(1, "simulation time limit");
  end

endmodule
`default_nettype wire
